// File: rtl/core_launcher.sv
// ----------------------------------------------------------------------------
// core_launcher
//   Launches an attached core and watches it run. A host request (i_go)
//   produces a REQ_LEN-cycle start pulse on o_req. The block then counts RUN
//   cycles until the core raises i_ack, and reports the count on o_cycles.
//   Every output is decoded from registered state, so there is no
//   combinational path from i_go or i_ack to any output.
//
//   Optional feature macro: CORE_LAUNCHER_WATCHDOG_EN
//     defined   : RUN gives up after TIMEOUT_CYCLES cycles (FAULT, o_timeout=1)
//     undefined : RUN waits for i_ack indefinitely and o_cycles saturates at
//                 all-ones; FAULT is unreachable and o_timeout is tied low
//
// Ports
//   i_clock    in   system clock, rising edge
//   i_reset    in   synchronous active-high reset
//   i_go       in   host launch request
//   i_ack      in   core completion flag
//   o_req      out  start/reset pulse to the core
//   o_busy     out  high in START and RUN
//   o_done     out  sticky, high in DONE
//   o_timeout  out  sticky, high in FAULT
//   o_cycles   out  RUN cycles elapsed before ack
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for the first launch after reset
// START | driving req to the core; ack ignored (core held in reset)
// RUN   | counting cycles until ack (or the watchdog expires)
// DONE  | core acknowledged; cycles frozen
// FAULT | watchdog expired without ack; cycles frozen
// ----------------------------------------------------------------------------
module core_launcher #(
    parameter int REQ_LEN        = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_go,
    input  logic             i_ack,
    output logic             o_req,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // START length is a down-counter loaded with REQ_LEN-1; terminal count
    // at zero moves on to RUN, giving exactly REQ_LEN cycles of req.
    localparam logic [3:0]       REQ_LOAD = 4'(REQ_LEN - 1);
    localparam logic [CNT_W-1:0] CYC_MAX  = '1;
`ifdef CORE_LAUNCHER_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_req_cnt;
    logic [3:0]       w_req_cnt_nxt;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] w_cycles_nxt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_req_cnt <= 4'd0;
            r_cycles  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_cnt <= w_req_cnt_nxt;
            r_cycles  <= w_cycles_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req_cnt_nxt = r_req_cnt;
        w_cycles_nxt  = r_cycles;

        case (r_state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (i_go) begin
                    w_state_nxt   = S_START;
                    w_req_cnt_nxt = REQ_LOAD;
                    w_cycles_nxt  = '0;
                end
            end

            S_START: begin
                if (r_req_cnt == 4'd0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_req_cnt_nxt = r_req_cnt - 4'd1;
                end
            end

            S_RUN: begin
                // ack is checked first so it wins a tie with the watchdog
                if (i_ack) begin
                    w_state_nxt = S_DONE;
`ifdef CORE_LAUNCHER_WATCHDOG_EN
                end else if (r_cycles == TIMEOUT_VAL) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_cycles_nxt = r_cycles + 1'b1;
                end
`else
                end else if (r_cycles != CYC_MAX) begin
                    w_cycles_nxt = r_cycles + 1'b1;
                end
`endif
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_req     = (r_state == S_START);
    assign o_busy    = (r_state == S_START) || (r_state == S_RUN);
    assign o_done    = (r_state == S_DONE);
`ifdef CORE_LAUNCHER_WATCHDOG_EN
    assign o_timeout = (r_state == S_FAULT);
`else
    assign o_timeout = 1'b0;
`endif
    assign o_cycles  = r_cycles;

endmodule

// File: tb/tb_core_launcher.sv
// ----------------------------------------------------------------------------
// tb_core_launcher
//   Directed bench for core_launcher. Two instances share clock and reset:
//     dut_a : REQ_LEN=2, CNT_W=16, TIMEOUT_CYCLES=20
//     dut_b : REQ_LEN=3, CNT_W=4,  TIMEOUT_CYCLES=10
//   Cycle k means the interval after rising edge k, where edge 0 is the edge
//   that samples go=1. Outputs are sampled 1 time unit after each edge.
// ----------------------------------------------------------------------------
module tb_core_launcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       go_a, ack_a, go_b, ack_b;
    logic       a_req, a_busy, a_done, a_to;
    logic       b_req, b_busy, b_done, b_to;
    logic [15:0] a_cyc;
    logic [3:0]  b_cyc;

    int n_cmp = 0;
    int n_bad = 0;

    core_launcher #(.REQ_LEN(2), .CNT_W(16), .TIMEOUT_CYCLES(20)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_go(go_a), .i_ack(ack_a),
        .o_req(a_req), .o_busy(a_busy), .o_done(a_done), .o_timeout(a_to),
        .o_cycles(a_cyc)
    );

    core_launcher #(.REQ_LEN(3), .CNT_W(4), .TIMEOUT_CYCLES(10)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_go(go_b), .i_ack(ack_b),
        .o_req(b_req), .o_busy(b_busy), .o_done(b_done), .o_timeout(b_to),
        .o_cycles(b_cyc)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // flags are {req, busy, done, timeout}
    task automatic chk(input string tag, input logic [3:0] obs_f, input logic [31:0] obs_c,
                       input logic [3:0] exp_f, input logic [31:0] exp_c);
        n_cmp++;
        assert (obs_f === exp_f) else begin
            n_bad++;
            $error("FAIL %s.flags(req,busy,done,to): observed %b expected %b", tag, obs_f, exp_f);
        end
        n_cmp++;
        assert (obs_c === exp_c) else begin
            n_bad++;
            $error("FAIL %s.cycles: observed %0d expected %0d", tag, obs_c, exp_c);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] exp_f, input logic [31:0] exp_c);
        chk(tag, {a_req, a_busy, a_done, a_to}, {16'd0, a_cyc}, exp_f, exp_c);
    endtask

    task automatic chk_b(input string tag, input logic [3:0] exp_f, input logic [31:0] exp_c);
        chk(tag, {b_req, b_busy, b_done, b_to}, {28'd0, b_cyc}, exp_f, exp_c);
    endtask

    initial begin
        rst = 1'b1; go_a = 1'b0; ack_a = 1'b0; go_b = 1'b0; ack_b = 1'b0;
        tick(2);
        chk_a("a_reset", 4'b0000, 0);
        chk_b("b_reset", 4'b0000, 0);
        go_a = 1'b1; ack_a = 1'b1;
        tick(1);
        chk_a("reset_over_go", 4'b0000, 0);
        rst = 1'b0; go_a = 1'b0; ack_a = 1'b0;
        tick(1);
        chk_a("idle", 4'b0000, 0);

        // normal run: ack at cycle 13 -> cycles 10, done from cycle 14
        go_a = 1'b1; tick(1); go_a = 1'b0;
        chk_a("norm_c1", 4'b1100, 0);
        tick(1);
        chk_a("norm_c2", 4'b1100, 0);
        tick(1);
        chk_a("norm_c3_run", 4'b0100, 0);
        tick(10);
        chk_a("norm_c13", 4'b0100, 10);
        ack_a = 1'b1; tick(1);
        chk_a("norm_c14_done", 4'b0010, 10);
        ack_a = 1'b0; tick(3);
        chk_a("norm_hold", 4'b0010, 10);

        // early ack: held high through START, DONE on first RUN cycle
        ack_a = 1'b1; go_a = 1'b1; tick(1); go_a = 1'b0;
        chk_a("early_c1", 4'b1100, 0);
        tick(2);
        chk_a("early_c3", 4'b0100, 0);
        tick(1);
        chk_a("early_c4", 4'b0010, 0);
        ack_a = 1'b0;

        // mid-run reset with go held high throughout
        go_a = 1'b1; tick(1);
        chk_a("mid_c1", 4'b1100, 0);
        tick(7);
        chk_a("mid_c8_norestart", 4'b0100, 5);
        rst = 1'b1; tick(1);
        chk_a("mid_reset", 4'b0000, 0);
        rst = 1'b0; go_a = 1'b0; tick(1);
        chk_a("mid_after", 4'b0000, 0);

`ifdef CORE_LAUNCHER_WATCHDOG_EN
        // timeout: cycles reaches 20 at cycle 23, FAULT at 24
        go_a = 1'b1; tick(1); go_a = 1'b0;
        tick(22);
        chk_a("to_c23", 4'b0100, 20);
        tick(1);
        chk_a("to_fault", 4'b0001, 20);
        tick(2);
        chk_a("to_hold", 4'b0001, 20);
        go_a = 1'b1; tick(1); go_a = 1'b0;
        chk_a("to_relaunch", 4'b1100, 0);
        // race: ack on the cycle cycles==20
        tick(22);
        chk_a("race_c23", 4'b0100, 20);
        ack_a = 1'b1; tick(1);
        chk_a("race_done", 4'b0010, 20);
        ack_a = 1'b0;

        // dut_b: REQ_LEN=3 boundary, then timeout at 10
        go_b = 1'b1; tick(1); go_b = 1'b0;
        tick(2);
        chk_b("b_c3_req", 4'b1100, 0);
        tick(1);
        chk_b("b_c4_run", 4'b0100, 0);
        tick(10);
        chk_b("b_c14", 4'b0100, 10);
        tick(1);
        chk_b("b_fault", 4'b0001, 10);
`else
        // no watchdog: RUN continues past TIMEOUT_CYCLES
        go_a = 1'b1; tick(1); go_a = 1'b0;
        tick(32);
        chk_a("nowd_c33", 4'b0100, 30);
        ack_a = 1'b1; tick(1);
        chk_a("nowd_done", 4'b0010, 30);
        ack_a = 1'b0;

        // dut_b: REQ_LEN=3 boundary, then saturation at 15
        go_b = 1'b1; tick(1); go_b = 1'b0;
        tick(2);
        chk_b("b_c3_req", 4'b1100, 0);
        tick(1);
        chk_b("b_c4_run", 4'b0100, 0);
        tick(15);
        chk_b("b_c19", 4'b0100, 15);
        tick(5);
        chk_b("b_sat", 4'b0100, 15);
        ack_b = 1'b1; tick(1);
        chk_b("b_done", 4'b0010, 15);
        ack_b = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_launcher.md
CORE_LAUNCHER -- requirements
Module: core_launcher

Interface
REQ-001 SHALL have parameter REQ_LEN, default 2, number of cycles req is held high per launch (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 16, width of the cycles output.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4000, RUN-state cycle budget before fault (legal range 1..2^CNT_W-2).
REQ-004 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port go  input  1  host launch request, sampled each clock.
REQ-007 SHALL have port ack  input  1  core completion flag (high while core PC sits at its done address).
REQ-008 SHALL have port req  output  1  start/reset pulse driven to the core's req input.
REQ-009 SHALL have port busy  output  1  high in START and RUN.
REQ-010 SHALL have port done  output  1  sticky, high in DONE.
REQ-011 SHALL have port timeout  output  1  sticky, high in FAULT.
REQ-012 SHALL have port cycles  output  CNT_W  RUN cycles elapsed before ack.

Function
REQ-013 SHALL implement states IDLE, START, RUN, DONE, FAULT; all outputs registered (decoded from state/counters), no combinational path from go or ack to any output.
REQ-014 IDLE, DONE, FAULT: go=1 -> START next cycle, cycles cleared to 0, done and timeout cleared; go=0 -> hold state.
REQ-015 START: req=1 for exactly REQ_LEN consecutive cycles, then RUN; ack ignored throughout START (core PC is in reset).
REQ-016 Latency: go sampled high at edge N -> req high from cycle N+1 through N+REQ_LEN, RUN entered at cycle N+REQ_LEN+1.
REQ-017 RUN: req=0; on each cycle with ack=0, cycles increments by 1; on the first cycle with ack=1 -> DONE, cycles not incremented on the ack cycle.
REQ-018 RUN: ack=0 with cycles == TIMEOUT_CYCLES -> FAULT, cycles holds TIMEOUT_CYCLES.
REQ-019 Simultaneous ack=1 and timeout condition in the same cycle: ack wins, state -> DONE.
REQ-020 go while in START or RUN SHALL be ignored (no restart, no counter change).
REQ-021 cycles SHALL hold its final value in DONE and FAULT until the next launch.
REQ-022 done and timeout SHALL never be high together; busy SHALL be low whenever done or timeout is high.

Reset
REQ-023 reset=1 at an edge SHALL force state IDLE, req=0, busy=0, done=0, timeout=0, cycles=0, REQ_LEN counter=0, overriding go and ack.
REQ-024 reset asserted mid-START or mid-RUN SHALL abort the launch; req drops the following cycle with no further pulse.

Configuration
REQ-025 Macro CORE_LAUNCHER_WATCHDOG_EN defined: timeout/FAULT behaviour per REQ-018/REQ-019.
REQ-026 Macro CORE_LAUNCHER_WATCHDOG_EN undefined: FAULT unreachable, timeout tied 0, RUN waits for ack indefinitely, cycles saturates at 2^CNT_W-1 instead of wrapping; TIMEOUT_CYCLES unused.

Verification
REQ-027 Normal run: reset, go=1 for one cycle at edge 0, ack=1 at cycle 3+10 -> req high cycles 1-2, busy high cycles 1-13, done=1 from cycle 14, cycles=10.
REQ-028 Timeout (macro defined, TIMEOUT_CYCLES=20): launch, ack held 0 -> timeout=1, done=0, cycles=20, busy=0; go again -> timeout cleared, req pulses again.
REQ-029 Early ack: ack held 1 from reset onward, launch -> ack ignored during START, DONE entered on first RUN cycle, cycles=0.
REQ-030 Race: TIMEOUT_CYCLES=20, ack rises on the cycle cycles==20 -> done=1, timeout=0, cycles=20.
REQ-031 Mid-run reset: launch, assert reset at RUN cycle 5 -> all outputs 0 next cycle; go held high during RUN before reset causes no restart.
REQ-032 Macro undefined, CNT_W=4, ack held 0 -> cycles saturates at 15, timeout stays 0, busy stays 1.
